data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder_pkg.sv | 39 +++
 rtl/data_bus_responder_tx_fifo.sv | 50 +++++
 rtl/data_bus_responder.sv | 171 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_responder_pkg.sv
// rtl/data_bus_responder_pkg.sv - shared MMIO map, STATUS layout and lane-merge helper
package data_bus_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [15:0] OFF_TXDATA      = 16'h0000;
  localparam logic [15:0] OFF_STATUS      = 16'h0004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'h0008;
  localparam logic [15:0] OFF_MTIME_HI    = 16'h000C;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h0010;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h0014;

  localparam int STATUS_FULL    = 0;
  localparam int STATUS_EMPTY   = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_CNT_LSB = 4;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TXDATA,
    REG_STATUS,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI
  } regSel_e;

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// rtl/data_bus_responder_tx_fifo.sv - register-based TX FIFO; a push into a full FIFO
// is accepted only when a pop happens on the same edge
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic                       notEmpty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             doPop;
  logic             doPush;

  assign notEmpty = (count != '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign doPop    = pop && notEmpty;
  assign doPush   = push && (!full || doPop);
  // Empty FIFO presents zero so the head byte is defined straight out of reset.
  assign headData = notEmpty ? store[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPush && !doPop)      count <= count + (PW+1)'(1);
      else if (doPop && !doPush) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && doPush) store[wrPtr] <= pushData;
  end

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - RAM + MMIO (TX FIFO, STATUS, optional timer) bus responder
// Timer registers and irq are built only when DBUS_TIMER_EN is defined.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wrData,
  input  logic        we,
  input  logic [3:0]  wrMask,
  output logic [31:0] rdData,
  output logic        fault,
  output logic        irq,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [MEM_WORDS];
  logic          ramHit;
  logic [AW-1:0] wordIdx;
  logic          inWindow;
  logic [15:0]   mmioOff;
  regSel_e       regSel;
  logic          unusedAddrBits;

  assign ramHit         = ({1'b0, addr} < (33'(MEM_WORDS) << 2));
  assign wordIdx        = addr[AW+1:2];
  assign inWindow       = (addr[31:16] == MMIO_BASE[31:16]);
  assign mmioOff        = {addr[15:2], 2'b00};
  assign unusedAddrBits = ^addr[1:0];

  always_comb begin
    regSel = REG_NONE;
    if (!ramHit && inWindow) begin
      case (mmioOff)
        OFF_TXDATA:      regSel = REG_TXDATA;
        OFF_STATUS:      regSel = REG_STATUS;
`ifdef DBUS_TIMER_EN
        OFF_MTIME_LO:    regSel = REG_MTIME_LO;
        OFF_MTIME_HI:    regSel = REG_MTIME_HI;
        OFF_MTIMECMP_LO: regSel = REG_MTIMECMP_LO;
        OFF_MTIMECMP_HI: regSel = REG_MTIMECMP_HI;
`endif
        default:         regSel = REG_NONE;
      endcase
    end
  end

  assign fault = !ramHit && (regSel == REG_NONE);

  always_ff @(posedge clk) begin
    if (!reset && we && ramHit) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  logic          enqReq;
  logic          deq;
  logic          fifoFull;
  logic [CW-1:0] fifoCount;
  logic          overflow;
  logic          ovfSet;
  logic          ovfClr;
  logic [31:0]   statusWord;

  assign enqReq = we && (regSel == REG_TXDATA) && wrMask[0];
  assign deq    = txValid && txReady;
  assign ovfSet = enqReq && fifoFull && !deq;
  assign ovfClr = we && (regSel == REG_STATUS) && wrMask[0] && wrData[STATUS_OVF];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (enqReq),
    .pushData (wrData[7:0]),
    .pop      (txReady),
    .headData (txData),
    .notEmpty (txValid),
    .full     (fifoFull),
    .count    (fifoCount)
  );

  // A new overflow on the clearing edge must not be lost, so set beats clear.
  always_ff @(posedge clk) begin
    if (reset)       overflow <= 1'b0;
    else if (ovfSet) overflow <= 1'b1;
    else if (ovfClr) overflow <= 1'b0;
  end

  always_comb begin
    statusWord                       = '0;
    statusWord[STATUS_FULL]          = fifoFull;
    statusWord[STATUS_EMPTY]         = !txValid;
    statusWord[STATUS_OVF]           = overflow;
    statusWord[STATUS_CNT_LSB +: 4]  = 4'(fifoCount);
  end

`ifdef DBUS_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtimeInc;
  logic [63:0] mtimeNext;
  logic [63:0] mtimecmpNext;
  logic        irqReg;

  // A written half takes the merged lanes instead of its increment; the other half keeps counting.
  always_comb begin
    mtimeInc     = mtime + 64'd1;
    mtimeNext    = mtimeInc;
    mtimecmpNext = mtimecmp;
    if (we) begin
      case (regSel)
        REG_MTIME_LO:    mtimeNext[31:0]     = mergeLanes(mtime[31:0], wrData, wrMask);
        REG_MTIME_HI:    mtimeNext[63:32]    = mergeLanes(mtime[63:32], wrData, wrMask);
        REG_MTIMECMP_LO: mtimecmpNext[31:0]  = mergeLanes(mtimecmp[31:0], wrData, wrMask);
        REG_MTIMECMP_HI: mtimecmpNext[63:32] = mergeLanes(mtimecmp[63:32], wrData, wrMask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      irqReg   <= 1'b0;
    end else begin
      mtime    <= mtimeNext;
      mtimecmp <= mtimecmpNext;
      irqReg   <= (mtime >= mtimecmp);
    end
  end

  assign irq = irqReg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdData = '0;
    if (ramHit) begin
      rdData = mem[wordIdx];
    end else begin
      case (regSel)
        REG_STATUS:      rdData = statusWord;
`ifdef DBUS_TIMER_EN
        REG_MTIME_LO:    rdData = mtime[31:0];
        REG_MTIME_HI:    rdData = mtime[63:32];
        REG_MTIMECMP_LO: rdData = mtimecmp[31:0];
        REG_MTIMECMP_HI: rdData = mtimecmp[63:32];
`endif
        default:         rdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - directed and random checks of data_bus_responder against a queue-based model
module tb_data_bus_responder;

  localparam int          MEMW  = 1024;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = BASE + 32'h00;
  localparam logic [31:0] A_ST  = BASE + 32'h04;
  localparam logic [31:0] A_MLO = BASE + 32'h08;
  localparam logic [31:0] A_MHI = BASE + 32'h0C;
  localparam logic [31:0] A_CLO = BASE + 32'h10;
  localparam logic [31:0] A_CHI = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset, we, txReady;
  logic [31:0] addr, wrData;
  logic [3:0]  wrMask;
  logic [31:0] rdData;
  logic        fault, irq, txValid;
  logic [7:0]  txData;

  always #5 clk = ~clk;

  data_bus_responder #(
    .MEM_WORDS  (MEMW),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wrData  (wrData),
    .we      (we),
    .wrMask  (wrMask),
    .rdData  (rdData),
    .fault   (fault),
    .irq     (irq),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady)
  );

  int nChecks = 0;
  int nErrors = 0;

  logic [31:0] ramM [int];
  byte unsigned q[$];
  logic        ovfM   = 1'b0;
  logic [63:0] mtimeM = '0;
  logic [63:0] cmpM   = '1;
  logic        irqM   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] laneWrite(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~bm) | (d & bm);
  endfunction

  function automatic void expRead(input logic [31:0] a, output logic [31:0] d,
                                  output logic f, output logic known);
    d = '0; f = 1'b0; known = 1'b1;
    if (a < MEMW*4) begin
      known = ramM.exists(int'(a[31:2]));
      if (known) d = ramM[int'(a[31:2])];
    end else if (a[31:16] == 16'hFFFF) begin
      case ({a[15:2], 2'b00})
        16'h0000: d = '0;
        16'h0004: d = {24'h0, 4'(q.size()), 1'b0, ovfM, (q.size() == 0), (q.size() == DEPTH)};
`ifdef DBUS_TIMER_EN
        16'h0008: d = mtimeM[31:0];
        16'h000C: d = mtimeM[63:32];
        16'h0010: d = cmpM[31:0];
        16'h0014: d = cmpM[63:32];
`endif
        default:  f = 1'b1;
      endcase
    end else begin
      f = 1'b1;
    end
  endfunction

  task automatic modelEdge(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m, input logic rdy);
    logic        deqM, enqM, wasFull, win;
    logic [15:0] off;
    logic [63:0] nt;
    if (r) begin
      q.delete(); ovfM = 1'b0; mtimeM = '0; cmpM = '1; irqM = 1'b0;
      return;
    end
    win = (a >= MEMW*4) && (a[31:16] == 16'hFFFF);
    off = {a[15:2], 2'b00};
`ifdef DBUS_TIMER_EN
    irqM = (mtimeM >= cmpM);
    nt = mtimeM + 64'd1;
    if (w && win && off == 16'h0008) nt[31:0]  = laneWrite(mtimeM[31:0], d, m);
    if (w && win && off == 16'h000C) nt[63:32] = laneWrite(mtimeM[63:32], d, m);
    if (w && win && off == 16'h0010) cmpM[31:0]  = laneWrite(cmpM[31:0], d, m);
    if (w && win && off == 16'h0014) cmpM[63:32] = laneWrite(cmpM[63:32], d, m);
    mtimeM = nt;
`else
    irqM = 1'b0;
    nt = '0;
`endif
    deqM    = (q.size() > 0) && rdy;
    enqM    = w && win && off == 16'h0000 && m[0];
    wasFull = (q.size() == DEPTH);
    if (w && win && off == 16'h0004 && m[0] && d[2]) ovfM = 1'b0;
    if (deqM) void'(q.pop_front());
    if (enqM) begin
      if (!wasFull || deqM) q.push_back(d[7:0]);
      else ovfM = 1'b1;
    end
    if (w && a < MEMW*4)
      ramM[int'(a[31:2])] = laneWrite(ramM.exists(int'(a[31:2])) ? ramM[int'(a[31:2])] : '0, d, m);
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic rdy);
    logic [31:0] ed;
    logic        ef, known;
    reset = r; we = w; addr = a; wrData = d; wrMask = m; txReady = rdy;
    #3;
    expRead(a, ed, ef, known);
    chk("fault", fault, ef);
    if (known) chk("rdData", rdData, ed);
    @(posedge clk);
    modelEdge(r, w, a, d, m, rdy);
    #1;
    chk("txValid", txValid, q.size() > 0);
    chk("txData", txData, (q.size() > 0) ? q[0] : 8'h00);
    chk("irq", irq, irqM);
  endtask

  initial begin
    logic [7:0]  heads [8];
    logic [31:0] pre, a, word0;
    logic        irqPre, seen;
    int          kind;

    // reset state
    cyc(1, 1, A_TX, 32'h77, 4'hF, 0);
    cyc(1, 0, A_ST, 0, 0, 0);
    chk("reset_status", rdData, 32'h2);
    chk("reset_txValid", txValid, 0);
    chk("reset_txData", txData, 0);
    chk("reset_irq", irq, 0);

    for (int i = 0; i < 16; i++) cyc(0, 1, 32'(i*4), $urandom, 4'hF, 0);
    word0 = ramM[0];

    // byte-lane write
    cyc(0, 1, 32'h10, 32'hAABBCCDD, 4'hF, 0);
    cyc(0, 1, 32'h10, 32'h00001100, 4'b0010, 0);
    cyc(0, 0, 32'h10, 0, 0, 0);
    chk("lane_merge", rdData, 32'hAABB11DD);

    // fill past full, then clear overflow
    for (int i = 0; i < 9; i++) cyc(0, 1, A_TX, 32'(8'h10 + i), 4'h1, 0);
    cyc(0, 0, A_ST, 0, 0, 0);
    chk("status_overflow", rdData, 32'h85);
    cyc(0, 1, A_ST, 32'h4, 4'h1, 0);
    chk("status_cleared", rdData, 32'h81);

    // enqueue into full FIFO alongside a dequeue
    cyc(0, 1, A_TX, 32'h5A, 4'h1, 1);
    cyc(0, 0, A_ST, 0, 0, 0);
    chk("full_enq_deq_status", rdData, 32'h81);
    for (int i = 0; i < 8; i++) begin
      heads[i] = txData;
      cyc(0, 0, A_ST, 0, 0, 1);
    end
    chk("eighth_byte", heads[7], 8'h5A);
    chk("first_after_head", heads[0], 8'h11);
    chk("drained_status", rdData, 32'h2);

    // unmapped addresses
    cyc(0, 0, MEMW*4, 0, 0, 0);
    chk("ram_end_fault", fault, 1);
    chk("ram_end_rd", rdData, 0);
    cyc(0, 0, BASE + 32'h18, 0, 0, 0);
    chk("mmio_hole_fault", fault, 1);
    chk("mmio_hole_rd", rdData, 0);
    cyc(0, 1, MEMW*4, 32'hDEADBEEF, 4'hF, 0);
    cyc(0, 1, BASE + 32'h18, 32'hFFFFFFFF, 4'hF, 0);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk("ram_word0_untouched", rdData, word0);
    cyc(0, 0, A_ST, 0, 0, 0);
    chk("status_untouched", rdData, 32'h2);

`ifdef DBUS_TIMER_EN
    // irq latency against MTIMECMP = 5
    cyc(0, 1, A_CLO, 5, 4'hF, 0);
    cyc(0, 1, A_CHI, 0, 4'hF, 0);
    cyc(0, 1, A_MHI, 0, 4'hF, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, A_MLO, 0, 4'hF, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      we = 0; addr = A_MLO;
      #3;
      pre = rdData; irqPre = irq;
      cyc(0, 0, A_MLO, 0, 0, 0);
      if (pre == 32'd5) begin
        chk("irq_low_at_5", irqPre, 0);
        chk("irq_high_after_5", irq, 1);
        seen = 1'b1;
      end
    end
    chk("mtime_reached_5", seen, 1);
`else
    cyc(0, 1, A_MLO, 32'h1234, 4'hF, 0);
    chk("timer_off_fault", fault, 1);
    chk("timer_off_rd", rdData, 0);
    chk("timer_off_irq", irq, 0);
`endif

    // reset mid-stream
    for (int i = 0; i < 3; i++) cyc(0, 1, A_TX, 32'(8'hC0 + i), 4'h1, 0);
`ifdef DBUS_TIMER_EN
    cyc(0, 1, A_MHI, 1, 4'hF, 0);
    cyc(0, 1, A_MLO, 0, 4'hF, 0);
    cyc(0, 0, A_MHI, 0, 0, 0);
    chk("mtime_hi_before_reset", rdData, 1);
`endif
    cyc(1, 1, A_TX, 32'hEE, 4'h1, 1);
    chk("reset_drops_queue", txValid, 0);
    chk("reset_irq_low", irq, 0);
`ifdef DBUS_TIMER_EN
    cyc(0, 0, A_MHI, 0, 0, 0);
    chk("mtime_hi_after_reset", rdData, 0);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1:    a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        2, 6:    a = A_TX;
        3:       a = A_ST + 32'($urandom_range(0, 3));
        4:       a = A_MLO + 32'($urandom_range(0, 3) * 4);
        5:       a = ($urandom_range(0, 1) == 1) ? 32'(MEMW*4 + $urandom_range(0, 255))
                                                 : BASE + 32'h18 + 32'($urandom_range(0, 1000) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
